// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared external combinational ALU.
// One operation is in flight at a time: IDLE (grant) -> EXEC (ALU settles) -> RESP (hold result).
module alu_arbiter #(
    parameter int DATA_W = 5
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ0_VALID,
    output logic              REQ0_READY,
    input  logic [3:0]        REQ0_OP,
    input  logic [DATA_W-1:0] REQ0_A,
    input  logic [DATA_W-1:0] REQ0_B,
    input  logic              REQ0_CIN,
    input  logic              REQ1_VALID,
    output logic              REQ1_READY,
    input  logic [3:0]        REQ1_OP,
    input  logic [DATA_W-1:0] REQ1_A,
    input  logic [DATA_W-1:0] REQ1_B,
    input  logic              REQ1_CIN,
    output logic              RSP0_VALID,
    input  logic              RSP0_READY,
    output logic              RSP1_VALID,
    input  logic              RSP1_READY,
    output logic [DATA_W-1:0] RSP_RESULT,
    output logic              RSP_COUT,
    output logic [3:0]        ALU_SEL,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_B,
    output logic              ALU_CIN,
    input  logic [DATA_W-1:0] ALU_SUM,
    input  logic              ALU_COUT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;   // id granted most recently; reset to 1 so REQ0 wins the first tie
    logic   owner;        // id of the operation currently in flight
    logic   grant;
    logic   accept;
    logic   rsp_ready_owner;

    // Grant: a lone requester wins outright, a tie goes to whoever was not served last.
    always_comb begin
        if (REQ0_VALID && REQ1_VALID) begin
            grant = ~last_grant;
        end else begin
            grant = REQ1_VALID;
        end
    end

    assign REQ0_READY      = (state == IDLE) && REQ0_VALID && !grant;
    assign REQ1_READY      = (state == IDLE) && REQ1_VALID && grant;
    assign accept          = REQ0_READY || REQ1_READY;
    assign rsp_ready_owner = owner ? RSP1_READY : RSP0_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            ALU_SEL    <= '0;
            ALU_A      <= '0;
            ALU_B      <= '0;
            ALU_CIN    <= 1'b0;
            RSP_RESULT <= '0;
            RSP_COUT   <= 1'b0;
            RSP0_VALID <= 1'b0;
            RSP1_VALID <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // ALU drive registers change only here, so they hold between operations.
                    if (accept) begin
                        ALU_SEL    <= grant ? REQ1_OP  : REQ0_OP;
                        ALU_A      <= grant ? REQ1_A   : REQ0_A;
                        ALU_B      <= grant ? REQ1_B   : REQ0_B;
                        ALU_CIN    <= grant ? REQ1_CIN : REQ0_CIN;
                        owner      <= grant;
                        last_grant <= grant;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    RSP_RESULT <= ALU_SUM;
                    RSP_COUT   <= ALU_COUT;
                    RSP0_VALID <= !owner;
                    RSP1_VALID <= owner;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready_owner) begin
                        RSP0_VALID <= 1'b0;
                        RSP1_VALID <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: acts as the shared ALU, keeps a transaction-level model
// of the arbiter and compares every output on every falling edge.
module tb_alu_arbiter;

    localparam int DATA_W = 5;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              REQ0_VALID, REQ1_VALID;
    logic              REQ0_READY, REQ1_READY;
    logic [3:0]        REQ0_OP, REQ1_OP;
    logic [DATA_W-1:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
    logic              REQ0_CIN, REQ1_CIN;
    logic              RSP0_VALID, RSP1_VALID;
    logic              RSP0_READY, RSP1_READY;
    logic [DATA_W-1:0] RSP_RESULT;
    logic              RSP_COUT;
    logic [3:0]        ALU_SEL;
    logic [DATA_W-1:0] ALU_A, ALU_B;
    logic              ALU_CIN;
    logic [DATA_W-1:0] ALU_SUM;
    logic              ALU_COUT;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.DATA_W(DATA_W)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_OP(REQ0_OP),
        .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_CIN(REQ0_CIN),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_OP(REQ1_OP),
        .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_CIN(REQ1_CIN),
        .RSP0_VALID(RSP0_VALID), .RSP0_READY(RSP0_READY),
        .RSP1_VALID(RSP1_VALID), .RSP1_READY(RSP1_READY),
        .RSP_RESULT(RSP_RESULT), .RSP_COUT(RSP_COUT),
        .ALU_SEL(ALU_SEL), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_CIN(ALU_CIN),
        .ALU_SUM(ALU_SUM), .ALU_COUT(ALU_COUT)
    );

    always #5 CLK = ~CLK;

    // Reference ALU: {carry, result}; carry is always the A+B+CIN carry.
    function automatic logic [5:0] alu_fn(input logic [3:0] op, input logic [4:0] a,
                                          input logic [4:0] b, input logic cin);
        logic [5:0] s;
        logic [4:0] r;
        s = {1'b0, a} + {1'b0, b} + {5'd0, cin};
        case (op)
            4'd1:    r = a - b;
            4'd2:    r = a ^ b;
            4'd3:    r = a & b;
            default: r = s[4:0];
        endcase
        return {s[5], r};
    endfunction

    always_comb begin
        {ALU_COUT, ALU_SUM} = alu_fn(ALU_SEL, ALU_A, ALU_B, ALU_CIN);
    end

    // Transaction-level model state
    bit         m_busy;
    bit         m_owner;
    int         m_age;      // cycles since acceptance while busy
    bit         m_last;     // requester served last
    logic [3:0] m_sel;
    logic [4:0] m_a, m_b;
    logic       m_cin;
    logic [4:0] m_res;
    logic       m_cout;

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_age = 0; m_last = 1;
        m_sel = 0; m_a = 0; m_b = 0; m_cin = 0; m_res = 0; m_cout = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model, then advance the model by one clock.
    task automatic check_and_advance();
        bit g, er0, er1, ev0, ev1;
        g   = (REQ0_VALID && REQ1_VALID) ? !m_last : REQ1_VALID;
        er0 = !m_busy && REQ0_VALID && !g;
        er1 = !m_busy && REQ1_VALID && g;
        ev0 = m_busy && m_age >= 2 && !m_owner;
        ev1 = m_busy && m_age >= 2 && m_owner;
        chk("req0_ready", REQ0_READY, er0);
        chk("req1_ready", REQ1_READY, er1);
        chk("rsp0_valid", RSP0_VALID, ev0);
        chk("rsp1_valid", RSP1_VALID, ev1);
        chk("rsp_result", RSP_RESULT, m_res);
        chk("rsp_cout", RSP_COUT, m_cout);
        chk("alu_sel", ALU_SEL, m_sel);
        chk("alu_a", ALU_A, m_a);
        chk("alu_b", ALU_B, m_b);
        chk("alu_cin", ALU_CIN, m_cin);
        if (!m_busy) begin
            if (REQ0_VALID || REQ1_VALID) begin
                m_busy = 1; m_owner = g; m_age = 1; m_last = g;
                m_sel = g ? REQ1_OP : REQ0_OP;
                m_a   = g ? REQ1_A  : REQ0_A;
                m_b   = g ? REQ1_B  : REQ0_B;
                m_cin = g ? REQ1_CIN : REQ0_CIN;
            end
        end else if (m_age == 1) begin
            {m_cout, m_res} = alu_fn(m_sel, m_a, m_b, m_cin);
            m_age = 2;
        end else if (m_owner ? RSP1_READY : RSP0_READY) begin
            m_busy = 0;
        end
    endtask

    // Inputs are set before calling; returns 1 time unit after the next rising edge.
    task automatic step();
        @(negedge CLK);
        check_and_advance();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int n, input bit v, input logic [3:0] op,
                           input logic [4:0] a, input logic [4:0] b, input logic cin);
        if (n == 0) begin
            REQ0_VALID = v; REQ0_OP = op; REQ0_A = a; REQ0_B = b; REQ0_CIN = cin;
        end else begin
            REQ1_VALID = v; REQ1_OP = op; REQ1_A = a; REQ1_B = b; REQ1_CIN = cin;
        end
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic pulse_reset();
        REQ0_VALID = 0; REQ1_VALID = 0;
        #1 RST_N = 0;
        #1;
        chk("rst_rsp0_valid", RSP0_VALID, 0);
        chk("rst_rsp1_valid", RSP1_VALID, 0);
        chk("rst_result", RSP_RESULT, 0);
        chk("rst_cout", RSP_COUT, 0);
        chk("rst_alu_sel", ALU_SEL, 0);
        chk("rst_alu_a", ALU_A, 0);
        chk("rst_alu_b", ALU_B, 0);
        chk("rst_alu_cin", ALU_CIN, 0);
        @(posedge CLK);
        #2 RST_N = 1;
        model_reset();
    endtask

    initial begin
        RST_N = 0;
        REQ0_VALID = 0; REQ1_VALID = 0;
        REQ0_OP = 0; REQ0_A = 0; REQ0_B = 0; REQ0_CIN = 0;
        REQ1_OP = 0; REQ1_A = 0; REQ1_B = 0; REQ1_CIN = 0;
        RSP0_READY = 0; RSP1_READY = 0;
        model_reset();
        #3;
        chk("init_rsp0_valid", RSP0_VALID, 0);
        chk("init_result", RSP_RESULT, 0);
        chk("init_alu_a", ALU_A, 0);
        repeat (2) @(posedge CLK);
        #2 RST_N = 1;

        // Add with wrap: 1F + 01 -> 00, carry 1; held 5 cycles with RSP1_READY pulsing
        set_req(0, 1, 4'd0, 5'h1F, 5'h01, 1'b0);
        step();
        chk("add_alu_a", ALU_A, 5'h1F);
        REQ0_VALID = 0;
        step();
        chk("add_rsp0_valid", RSP0_VALID, 1);
        chk("add_result", RSP_RESULT, 5'h00);
        chk("add_cout", RSP_COUT, 1);
        chk("add_rsp1_valid", RSP1_VALID, 0);
        REQ0_VALID = 1; REQ1_VALID = 1;
        for (int i = 0; i < 5; i++) begin
            RSP1_READY = i[0];
            step();
            chk("hold_rsp0_valid", RSP0_VALID, 1);
            chk("hold_result", RSP_RESULT, 5'h00);
        end
        REQ0_VALID = 0; REQ1_VALID = 0;
        RSP0_READY = 1; RSP1_READY = 0;
        step();
        chk("hs_rsp0_valid", RSP0_VALID, 0);

        // Subtract on requester 1: 03 - 05 -> 1E, carry 0
        set_req(1, 1, 4'd1, 5'h03, 5'h05, 1'b0);
        step();
        REQ1_VALID = 0;
        step();
        chk("sub_rsp1_valid", RSP1_VALID, 1);
        chk("sub_rsp0_valid", RSP0_VALID, 0);
        chk("sub_result", RSP_RESULT, 5'h1E);
        chk("sub_cout", RSP_COUT, 0);
        RSP1_READY = 1;
        step();

        // Both valid after reset: REQ0 first, then alternate
        pulse_reset();
        set_req(0, 1, 4'd2, 5'h0F, 5'h05, 1'b0);
        set_req(1, 1, 4'd3, 5'h0F, 5'h05, 1'b0);
        RSP0_READY = 1; RSP1_READY = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_alu_sel", ALU_SEL, (k % 2 == 0) ? 2 : 3);
            step();
            chk("rr_result", RSP_RESULT, (k % 2 == 0) ? 5'h0A : 5'h05);
            chk("rr_rsp1_valid", RSP1_VALID, k % 2);
            step();
        end

        // Reset during EXEC aborts; acceptance possible right after release
        REQ1_VALID = 0;
        set_req(0, 1, 4'd0, 5'h07, 5'h02, 1'b1);
        step();
        pulse_reset();
        set_req(1, 1, 4'd14, 5'h11, 5'h12, 1'b1);
        step();
        chk("post_rst_alu_sel", ALU_SEL, 14);
        chk("post_rst_rsp0_valid", RSP0_VALID, 0);
        REQ1_VALID = 0;
        step();
        chk("op14_result", RSP_RESULT, 5'h04);
        chk("op14_cout", RSP_COUT, 1);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            if (c == 200) pulse_reset();
            set_req(0, $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)),
                    5'($urandom), 5'($urandom), 1'($urandom));
            set_req(1, $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)),
                    5'($urandom), 5'($urandom), 1'($urandom));
            RSP0_READY = $urandom_range(0, 4) < 3;
            RSP1_READY = $urandom_range(0, 4) < 3;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
